melody_sequencer: RTL and testbench
===================================

# melody_sequencer

Plays a fixed 16-entry note table by stepping through it on a tempo tick. Each step drives a 4-bit semitone index plus a sound-enable. It sits directly upstream of the octave tone decoder: `tone` feeds the decoder's tone input, and `enableSound` gates the prescaler/square-wave stage behind it. Start, stop and loop controls come from the game/keypad logic.

## Interface
- `TICK_DIV`, default 6_250_000: clock cycles per tempo tick (125 ms at 50 MHz); legal range ≥ 2.
- `GAP_TICKS`, default 1: silent ticks inserted after every note; 0 means no gap.
- `clk`  in  1  system clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `start`  in  1  level, sampled each cycle; starts playback from entry 0 when idle.
- `stop`  in  1  aborts playback; wins over `start` in the same cycle.
- `loop`  in  1  sampled at end of song; if high, playback restarts at entry 0.
- `tone`  out  4  semitone index, 0 = do … 11 = si; registered.
- `enableSound`  out  1  high while a non-rest note is sounding; registered.
- `noteStrobe`  out  1  one-cycle pulse on the cycle a new note/rest begins.
- `noteIndex`  out  4  table entry currently playing.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on natural end of song with `loop` low.

## Operation
- Song table: 16 × 8-bit constant, fixed in RTL. Bits [7:4] are the tone; bits [3:0] are the duration in ticks.
  - Duration 0 is the end-of-song marker.
  - Tone 12–15 is a rest: `enableSound` = 0, `tone` holds 0. The decoder is never fed an index > 11.
- Default table, entries 0–5: (0,2), (2,2), (4,2), (12,1), (9,4), (x,0). Entries 6–15 are (x,0).
- FSM states: IDLE, LOAD, NOTE, GAP.
  - IDLE: when `start` is high and `stop` is low, clear the index and go to LOAD.
  - LOAD, one cycle, reads entry[index]:
    - If duration = 0 and `loop` = 1: index ← 0 and stay in LOAD.
    - If duration = 0 and `loop` = 0: pulse `done` and go to IDLE.
    - Otherwise register `tone`/`enableSound`, pulse `noteStrobe`, clear the tick and beat counters, and go to NOTE.
  - NOTE: lasts duration × `TICK_DIV` cycles, then `enableSound` ← 0.
    - If `GAP_TICKS` > 0, go to GAP.
    - Otherwise index ← index+1 and go to LOAD.
  - GAP: lasts `GAP_TICKS` × `TICK_DIV` cycles with `enableSound` = 0, then index ← index+1 and go to LOAD.
  - Index wrap: after entry 15, the index wraps to 0. It is treated as end of song, the same as duration 0, honouring `loop`.
- Counters:
  - Tick counter is ⌈log2 `TICK_DIV`⌉ bits; it counts 0..`TICK_DIV`−1 and emits an internal tick at the terminal count.
  - Beat counter is 4 bits and counts ticks against the duration or `GAP_TICKS`.
  - Both counters are held at 0 in IDLE.
- `stop` in any non-IDLE state: next state is IDLE, `enableSound` ← 0, no `done` pulse.
- `start` while `busy`: ignored, no restart.

## Timing
- Reset values: `tone` = 0, `enableSound` = 0, `noteStrobe` = 0, `noteIndex` = 0, `busy` = 0, `done` = 0, state IDLE, counters 0.
- Reset mid-playback: same values immediately, asynchronously.
- `start` sampled at edge k:
  - LOAD at k+1.
  - `tone`, `enableSound` and `noteStrobe` valid after edge k+2.
- Note cadence: each table step occupies 1 + (duration + `GAP_TICKS`) × `TICK_DIV` cycles, counted from `noteStrobe` to the next `noteStrobe`.
- End of song: `done` pulses exactly one cycle, the cycle after the final LOAD; `busy` falls at the same edge.
- Loop restart: adds one extra LOAD cycle (the marker read) before entry 0's `noteStrobe`.
- `stop` sampled at edge k: `busy` = 0 and `enableSound` = 0 after edge k+1.

## Test plan
- Basic play (`TICK_DIV`=4, `GAP_TICKS`=1, reset then `start` pulse):
  - `noteStrobe` pulses 13 cycles apart with tones 0, 2, 4.
  - The rest step (tone 12) shows `enableSound` = 0 and `tone` = 0 for 4 cycles.
  - Tone 9 sounds for 16 cycles.
  - `done` pulses once and `busy` falls.
- `GAP_TICKS`=0: `enableSound` stays high across consecutive non-rest notes except the single LOAD cycle; spacing is 9 cycles for duration 2.
- `loop`=1 held through end of song: after tone 9, entry 0 (tone 0) restarts; no `done` pulse; `busy` stays high.
- `stop` asserted mid-note 2:
  - Next cycle `busy` = 0 and `enableSound` = 0, with no `done`.
  - A subsequent `start` restarts at `noteIndex` 0.
- `start` and `stop` high together from IDLE → stays IDLE. `start` re-pulsed during playback → no change in `noteIndex` sequence.
- `resetN` low mid-note → all outputs 0 asynchronously; after release, stays IDLE until `start`.

Source files
------------

// File: rtl/melody_sequencer.sv
// Steps through a fixed 16-entry note table on a tempo tick.
// Each step drives a semitone index and a sound enable for the octave tone decoder.
//   state  | meaning
//   IDLE   | silent, waiting for start
//   LOAD   | one cycle: read entry[index], start a note or end the song
//   NOTE   | note or rest sounding for duration ticks
//   GAP    | silent ticks between notes
module melody_sequencer #(
  parameter int TICK_DIV  = 6_250_000,
  parameter int GAP_TICKS = 1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [3:0] tone,
  output logic       enableSound,
  output logic       noteStrobe,
  output logic [3:0] noteIndex,
  output logic       busy,
  output logic       done
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_NOTE, S_GAP} state_t;

  state_t        r_state, w_state;
  logic          r_start, r_stop;
  logic [3:0]    r_index, w_index;
  logic          r_wrap, w_wrap;
  logic [3:0]    r_tone, w_tone;
  logic          r_en, w_en;
  logic          r_strobe, w_strobe;
  logic          r_done, w_done;
  logic [3:0]    r_dur, w_dur;
  logic [TW-1:0] r_tick, w_tick;
  logic [3:0]    r_beat, w_beat;
  logic [7:0]    w_entry;
  logic          w_tick_tc;
  logic          w_is_rest;

  always_comb begin
    w_entry = 8'h00;
    case (r_index)
      4'd0:    w_entry = 8'h02;
      4'd1:    w_entry = 8'h22;
      4'd2:    w_entry = 8'h42;
      4'd3:    w_entry = 8'hC1;
      4'd4:    w_entry = 8'h94;
      default: w_entry = 8'h00;
    endcase
  end

  assign w_tick_tc = (r_tick == TW'(TICK_DIV - 1));
  assign w_is_rest = (w_entry[7:4] > 4'd11);

  always_comb begin
    w_state  = r_state;
    w_index  = r_index;
    w_wrap   = r_wrap;
    w_tone   = r_tone;
    w_en     = r_en;
    w_strobe = 1'b0;
    w_done   = 1'b0;
    w_dur    = r_dur;
    w_tick   = '0;
    w_beat   = 4'd0;
    case (r_state)
      S_IDLE: begin
        if (r_start && !r_stop) begin
          w_state = S_LOAD;
          w_index = 4'd0;
          w_wrap  = 1'b0;
        end
      end
      S_LOAD: begin
        // a wrapped index counts as the end-of-song marker
        if (w_entry[3:0] == 4'd0 || r_wrap) begin
          if (loop) begin
            w_index = 4'd0;
            w_wrap  = 1'b0;
          end else begin
            w_done  = 1'b1;
            w_state = S_IDLE;
          end
        end else begin
          w_tone   = w_is_rest ? 4'd0 : w_entry[7:4];
          w_en     = !w_is_rest;
          w_strobe = 1'b1;
          w_dur    = w_entry[3:0];
          w_state  = S_NOTE;
        end
      end
      S_NOTE: begin
        w_tick = w_tick_tc ? '0 : r_tick + 1'b1;
        w_beat = w_tick_tc ? r_beat + 4'd1 : r_beat;
        if (w_tick_tc && r_beat == r_dur - 4'd1) begin
          w_en   = 1'b0;
          w_tick = '0;
          w_beat = 4'd0;
          if (GAP_TICKS > 0) begin
            w_state = S_GAP;
          end else begin
            w_index = r_index + 4'd1;
            w_wrap  = (r_index == 4'd15);
            w_state = S_LOAD;
          end
        end
      end
      S_GAP: begin
        w_tick = w_tick_tc ? '0 : r_tick + 1'b1;
        w_beat = w_tick_tc ? r_beat + 4'd1 : r_beat;
        if (w_tick_tc && r_beat == 4'(GAP_TICKS - 1)) begin
          w_tick  = '0;
          w_beat  = 4'd0;
          w_index = r_index + 4'd1;
          w_wrap  = (r_index == 4'd15);
          w_state = S_LOAD;
        end
      end
      default: w_state = S_IDLE;
    endcase
    if (r_state != S_IDLE && r_stop) begin
      w_state  = S_IDLE;
      w_en     = 1'b0;
      w_strobe = 1'b0;
      w_done   = 1'b0;
      w_tick   = '0;
      w_beat   = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state  <= S_IDLE;
      r_start  <= 1'b0;
      r_stop   <= 1'b0;
      r_index  <= 4'd0;
      r_wrap   <= 1'b0;
      r_tone   <= 4'd0;
      r_en     <= 1'b0;
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      r_dur    <= 4'd0;
      r_tick   <= '0;
      r_beat   <= 4'd0;
    end else begin
      r_state  <= w_state;
      r_start  <= start;
      r_stop   <= stop;
      r_index  <= w_index;
      r_wrap   <= w_wrap;
      r_tone   <= w_tone;
      r_en     <= w_en;
      r_strobe <= w_strobe;
      r_done   <= w_done;
      r_dur    <= w_dur;
      r_tick   <= w_tick;
      r_beat   <= w_beat;
    end
  end

  assign tone        = r_tone;
  assign enableSound = r_en;
  assign noteStrobe  = r_strobe;
  assign noteIndex   = r_index;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed-vector bench for melody_sequencer: TICK_DIV=4 with one gap tick,
// plus a gap-free instance for note spacing.
module tb_melody_sequencer;
  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic       start0 = 1'b0, stop0 = 1'b0, loop0 = 1'b0;
  logic [3:0] tone, noteIndex, tone0, noteIndex0;
  logic       enableSound, noteStrobe, busy, done;
  logic       enableSound0, noteStrobe0, busy0, done0;

  always #5 clk = ~clk;

  melody_sequencer #(.TICK_DIV(4), .GAP_TICKS(1)) dut (
    .clk(clk), .resetN(resetN), .start(start), .stop(stop), .loop(loop),
    .tone(tone), .enableSound(enableSound), .noteStrobe(noteStrobe),
    .noteIndex(noteIndex), .busy(busy), .done(done)
  );

  melody_sequencer #(.TICK_DIV(4), .GAP_TICKS(0)) dut0 (
    .clk(clk), .resetN(resetN), .start(start0), .stop(stop0), .loop(loop0),
    .tone(tone0), .enableSound(enableSound0), .noteStrobe(noteStrobe0),
    .noteIndex(noteIndex0), .busy(busy0), .done(done0)
  );

  typedef struct {
    int         cyc;
    logic       st, sp, lp;
    logic [3:0] tone;
    logic       en, stb;
    logic [3:0] idx;
    logic       busy, done;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0, checks = 0, cyc = 0, n_done = 0, n_strobe = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (noteStrobe) n_strobe++;
    if (done) n_done++;
  endtask

  task automatic add(input int c, input logic st, input logic sp, input logic lp,
                     input logic [3:0] t, input logic e, input logic s,
                     input logic [3:0] i, input logic b, input logic d);
    vec_t v;
    v.cyc = c; v.st = st; v.sp = sp; v.lp = lp;
    v.tone = t; v.en = e; v.stb = s; v.idx = i; v.busy = b; v.done = d;
    vecs.push_back(v);
  endtask

  initial begin
    int         strobes[$];
    int         tones[$];
    int         en_low;
    int         s0;
    logic [11:0] act, exp;

    //   cyc  st sp lp tone en stb idx busy done
    add(  0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(  2, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(  3, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    add(  4, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    add( 10, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    add( 11, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add( 15, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    add( 16, 0, 0, 0, 2, 1, 1, 1, 1, 0);
    add( 29, 0, 0, 0, 4, 1, 1, 2, 1, 0);
    add( 42, 0, 0, 0, 0, 0, 1, 3, 1, 0);
    add( 45, 0, 0, 0, 0, 0, 0, 3, 1, 0);
    add( 46, 0, 0, 0, 0, 0, 0, 3, 1, 0);
    add( 50, 0, 0, 0, 0, 0, 0, 4, 1, 0);
    add( 51, 0, 0, 0, 9, 1, 1, 4, 1, 0);
    add( 66, 0, 0, 0, 9, 1, 0, 4, 1, 0);
    add( 67, 0, 0, 0, 9, 0, 0, 4, 1, 0);
    add( 71, 0, 0, 0, 9, 0, 0, 5, 1, 0);
    add( 72, 0, 0, 0, 9, 0, 0, 5, 0, 1);
    add( 73, 0, 0, 0, 9, 0, 0, 5, 0, 0);
    add( 80, 1, 0, 1, 9, 0, 0, 5, 0, 0);
    add( 81, 0, 0, 1, 9, 0, 0, 5, 0, 0);
    add( 82, 0, 0, 1, 9, 0, 0, 0, 1, 0);
    add( 83, 0, 0, 1, 0, 1, 1, 0, 1, 0);
    add( 96, 0, 0, 1, 2, 1, 1, 1, 1, 0);
    add(100, 1, 0, 1, 2, 1, 0, 1, 1, 0);
    add(101, 0, 0, 1, 2, 1, 0, 1, 1, 0);
    add(109, 0, 0, 1, 4, 1, 1, 2, 1, 0);
    add(131, 0, 0, 1, 9, 1, 1, 4, 1, 0);
    add(151, 0, 0, 1, 9, 0, 0, 5, 1, 0);
    add(152, 0, 0, 1, 9, 0, 0, 0, 1, 0);
    add(153, 0, 0, 1, 0, 1, 1, 0, 1, 0);
    add(166, 0, 0, 1, 2, 1, 1, 1, 1, 0);
    add(168, 0, 1, 1, 2, 1, 0, 1, 1, 0);
    add(169, 0, 1, 1, 2, 1, 0, 1, 1, 0);
    add(170, 0, 0, 0, 2, 0, 0, 1, 0, 0);
    add(175, 1, 0, 0, 2, 0, 0, 1, 0, 0);
    add(176, 0, 0, 0, 2, 0, 0, 1, 0, 0);
    add(177, 0, 0, 0, 2, 0, 0, 0, 1, 0);
    add(178, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    add(180, 0, 1, 0, 0, 1, 0, 0, 1, 0);
    add(182, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(186, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(190, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(193, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("reset_held", {tone, enableSound, noteStrobe, noteIndex, busy, done}, 0);
    resetN = 1'b1;
    cyc = 0;

    foreach (vecs[n]) begin
      while (cyc < vecs[n].cyc) step();
      act = {tone, enableSound, noteStrobe, noteIndex, busy, done};
      exp = {vecs[n].tone, vecs[n].en, vecs[n].stb, vecs[n].idx, vecs[n].busy, vecs[n].done};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL vec cyc=%0d: got tone=%0d en=%0b stb=%0b idx=%0d busy=%0b done=%0b, expected tone=%0d en=%0b stb=%0b idx=%0d busy=%0b done=%0b",
                 vecs[n].cyc, act[11:8], act[7], act[6], act[5:2], act[1], act[0],
                 exp[11:8], exp[7], exp[6], exp[5:2], exp[1], exp[0]);
      end
      start = vecs[n].st;
      stop  = vecs[n].sp;
      loop  = vecs[n].lp;
    end
    chk("done_pulse_count", n_done, 1);
    chk("strobe_count", n_strobe, 13);

    // gap-free instance: consecutive notes separated by a single LOAD cycle
    en_low = 0;
    start0 = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j == 1) start0 = 1'b0;
      if (noteStrobe0) begin
        strobes.push_back(j);
        tones.push_back(int'(tone0));
      end
      if (j >= 3 && j < 21 && !enableSound0) en_low++;
    end
    chk("gap0_strobes", strobes.size(), 5);
    if (strobes.size() >= 3) begin
      chk("gap0_first_strobe", strobes[0], 3);
      chk("gap0_spacing_1", strobes[1] - strobes[0], 9);
      chk("gap0_spacing_2", strobes[2] - strobes[1], 9);
      chk("gap0_tone_3", tones[2], 4);
    end
    chk("gap0_en_low_cycles", en_low, 2);

    // asynchronous reset in the middle of note 1
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (17) step();
    chk("pre_reset_note", {tone, enableSound, noteIndex, busy}, {4'd2, 1'b1, 4'd1, 1'b1});
    #2 resetN = 1'b0;
    #1 chk("async_reset", {tone, enableSound, noteStrobe, noteIndex, busy, done}, 0);
    @(negedge clk);
    resetN = 1'b1;
    s0 = n_strobe;
    repeat (10) step();
    chk("idle_after_reset_busy", busy, 0);
    chk("idle_after_reset_strobes", n_strobe - s0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
